// File: rtl/decrypt_dispatch_pipe.sv
// decrypt_dispatch_pipe: two-stage valid/ready pipeline that decodes a mode from
// the frame selector and applies one of four decrypt transforms.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_frame = {payload, key, sel}
//   out_valid/out_ready : output handshake, out_data = plaintext, out_mode = mode used
//   frame_count         : delivered frames, wraps
//   stats_sel/stats_count : per-mode delivered count (combinational read)
// Optional feature macro: DECRYPT_STATS_EN builds saturating per-mode counters;
// without it stats_count is tied to 0.
module decrypt_dispatch_pipe #(
  parameter int unsigned PAY_W = 60,
  parameter int unsigned KEY_W = 12,
  parameter int unsigned SEL_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PAY_W+KEY_W+SEL_W-1:0]   in_frame,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PAY_W-1:0]               out_data,
  output logic [1:0]                     out_mode,
  output logic [CNT_W-1:0]               frame_count,
  input  logic [1:0]                     stats_sel,
  output logic [CNT_W-1:0]               stats_count
);

  localparam int unsigned ROT_W = SEL_W - 2;

  // Frame field split
  logic [SEL_W-1:0] in_sel;
  logic [KEY_W-1:0] in_key;
  logic [PAY_W-1:0] in_pay;
  assign in_sel = in_frame[SEL_W-1:0];
  assign in_key = in_frame[SEL_W +: KEY_W];
  assign in_pay = in_frame[SEL_W+KEY_W +: PAY_W];

  // Key expansion: bit i of the expanded key is key bit (i mod KEY_W)
  logic [PAY_W-1:0] key_exp;
  always_comb begin
    key_exp = '0;
    for (int i = 0; i < int'(PAY_W); i++) begin
      key_exp[i] = in_key[i % int'(KEY_W)];
    end
  end

  // Stage 1 registers
  logic             s1_valid;
  logic [PAY_W-1:0] s1_pay;
  logic [PAY_W-1:0] s1_key;
  logic [1:0]       s1_mode;
  logic [ROT_W-1:0] s1_rot;

  // Advance control
  logic s2_load;
  logic s1_load;
  logic out_fire;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign s1_load  = in_valid && (!s1_valid || s2_load);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign out_fire = out_valid && out_ready;

  // Stage 1: capture payload, expanded key, mode and rotate amount
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid <= 1'b0;
      s1_pay   <= '0;
      s1_key   <= '0;
      s1_mode  <= 2'b00;
      s1_rot   <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_pay   <= in_pay;
      s1_key   <= key_exp;
      s1_mode  <= in_sel[SEL_W-1 -: 2];
      s1_rot   <= in_sel[ROT_W-1:0];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Transform datapath; rotate via doubled word so r=0 passes P through
  logic [2*PAY_W-1:0] rot_wide;
  logic [PAY_W-1:0]   pay_rev;
  logic [PAY_W-1:0]   xform;
  always_comb begin
    rot_wide = {s1_pay, s1_pay} >> s1_rot;
    pay_rev  = '0;
    for (int i = 0; i < int'(PAY_W); i++) begin
      pay_rev[i] = s1_pay[int'(PAY_W) - 1 - i];
    end
    xform = s1_pay ^ s1_key;
    case (s1_mode)
      2'd0:    xform = s1_pay ^ s1_key;
      2'd1:    xform = rot_wide[PAY_W-1:0] ^ s1_key;
      2'd2:    xform = s1_pay - s1_key;
      default: xform = pay_rev ^ s1_key;
    endcase
  end

  // Stage 2: output register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 2'b00;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= xform;
      out_mode  <= s1_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered frame counter, wraps
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_count <= '0;
    end else if (out_fire) begin
      frame_count <= frame_count + CNT_W'(1);
    end
  end

`ifdef DECRYPT_STATS_EN
  // Per-mode saturating delivery counters
  logic [CNT_W-1:0] mode_cnt [4];
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int m = 0; m < 4; m++) begin
        mode_cnt[m] <= '0;
      end
    end else if (out_fire && (mode_cnt[out_mode] != '1)) begin
      mode_cnt[out_mode] <= mode_cnt[out_mode] + CNT_W'(1);
    end
  end
  assign stats_count = mode_cnt[stats_sel];
`else
  logic unused_stats_sel;
  assign unused_stats_sel = ^stats_sel;
  assign stats_count = '0;
`endif

endmodule

// File: tb/tb_decrypt_dispatch_pipe.sv
// Bench for decrypt_dispatch_pipe: directed test-plan steps followed by random
// valid/ready traffic scored against a spec-level model queue.
module tb_decrypt_dispatch_pipe;

  localparam int unsigned PAY_W = 60;
  localparam int unsigned KEY_W = 12;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FR_W  = PAY_W + KEY_W + SEL_W;
`ifdef DECRYPT_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic             Clk;
  logic             Rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [FR_W-1:0]  in_frame;
  logic             out_valid;
  logic             out_ready;
  logic [PAY_W-1:0] out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] frame_count;
  logic [1:0]       stats_sel;
  logic [CNT_W-1:0] stats_count;

  decrypt_dispatch_pipe #(
    .PAY_W(PAY_W), .KEY_W(KEY_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_frame(in_frame),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode),
    .frame_count(frame_count),
    .stats_sel(stats_sel), .stats_count(stats_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [PAY_W-1:0] q_data[$];
  logic [1:0]       q_mode[$];
  logic [CNT_W-1:0] exp_cnt;
  int               exp_stats[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec-level model: mode by selector range, key bit i = key[i mod KEY_W]
  task automatic model(input logic [FR_W-1:0] f, output logic [PAY_W-1:0] d, output logic [1:0] m);
    logic [PAY_W-1:0] p, k, t;
    logic [KEY_W-1:0] key;
    int sv, r, md;
    p   = f[FR_W-1 -: PAY_W];
    key = f[SEL_W +: KEY_W];
    sv  = int'(f[SEL_W-1:0]);
    md  = sv / (1 << (SEL_W - 2));
    r   = sv % (1 << (SEL_W - 2));
    for (int i = 0; i < int'(PAY_W); i++) k[i] = key[i % int'(KEY_W)];
    t = '0;
    case (md)
      0: d = p ^ k;
      1: begin
        for (int i = 0; i < int'(PAY_W); i++) t[i] = p[(i + r) % int'(PAY_W)];
        d = t ^ k;
      end
      2: d = p - k;
      default: begin
        for (int i = 0; i < int'(PAY_W); i++) t[int'(PAY_W) - 1 - i] = p[i];
        d = t ^ k;
      end
    endcase
    m = 2'(md);
  endtask

  function automatic logic [63:0] exp_stat(input logic [1:0] s);
    return STATS_ON ? 64'(exp_stats[s]) : 64'h0;
  endfunction

  // One clock: drive at negedge, score transfers just before posedge, check counters after
  task automatic cycle(input logic v, input logic [FR_W-1:0] f, input logic ordy, output bit acc);
    logic [PAY_W-1:0] d;
    logic [1:0]       m;
    in_valid  = v;
    in_frame  = f;
    out_ready = ordy;
    stats_sel = 2'($urandom_range(0, 3));
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q_data.size() == 0) begin
        chk("out_unexpected", 64'(out_valid), 64'h0);
      end else begin
        m = q_mode.pop_front();
        chk("out_data", 64'(out_data), 64'(q_data.pop_front()));
        chk("out_mode", 64'(out_mode), 64'(m));
        if (exp_stats[m] < (1 << CNT_W) - 1) exp_stats[m]++;
      end
      exp_cnt = exp_cnt + CNT_W'(1);
    end
    if (acc) begin
      model(f, d, m);
      q_data.push_back(d);
      q_mode.push_back(m);
    end
    @(posedge Clk);
    @(negedge Clk);
    chk("frame_count", 64'(frame_count), 64'(exp_cnt));
    chk("stats_count", 64'(stats_count), exp_stat(stats_sel));
  endtask

  task automatic clear_model();
    q_data.delete();
    q_mode.delete();
    exp_cnt = '0;
    for (int i = 0; i < 4; i++) exp_stats[i] = 0;
  endtask

  // Directed frame through an empty pipe: 2-cycle latency, known plaintext
  task automatic directed(input string tag, input logic [FR_W-1:0] f,
                          input logic [PAY_W-1:0] exp_d, input logic [1:0] exp_m);
    bit acc;
    cycle(1'b1, f, 1'b1, acc);
    chk({tag, "_acc"}, 64'(acc), 64'h1);
    chk({tag, "_lat1_valid"}, 64'(out_valid), 64'h0);
    cycle(1'b0, '0, 1'b1, acc);
    chk({tag, "_lat2_valid"}, 64'(out_valid), 64'h1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
    chk({tag, "_mode"}, 64'(out_mode), 64'(exp_m));
  endtask

  function automatic logic [FR_W-1:0] mk(input logic [PAY_W-1:0] p, input logic [KEY_W-1:0] k,
                                         input logic [SEL_W-1:0] s);
    return {p, k, s};
  endfunction

  function automatic logic [FR_W-1:0] rand_frame();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[FR_W-1:0];
  endfunction

  initial begin
    bit acc;
    bit have;
    logic [FR_W-1:0] cur;

    Rst_n = 1'b0; in_valid = 1'b0; in_frame = '0; out_ready = 1'b0; stats_sel = 2'd0;
    clear_model();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_mode", 64'(out_mode), 64'h0);
    chk("rst_frame_count", 64'(frame_count), 64'h0);
    chk("rst_stats", 64'(stats_count), 64'h0);
    @(negedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);
    @(negedge Clk);

    // Test-plan transforms, including wrap on subtract and r=1 rotate
    directed("mode0", mk(60'h123456789ABCDEF, 12'hABC, 6'h05), 60'hB9FEEAD35000753, 2'd0);
    directed("mode2", mk(60'h0, 12'h001, 6'h20), 60'hFFEFFEFFEFFEFFF, 2'd2);
    directed("mode1", mk(60'h1, 12'h000, 6'h11), 60'h800000000000000, 2'd1);
    directed("mode3", mk(60'h3, 12'h000, 6'h30), 60'hC00000000000000, 2'd3);
    directed("mode1_r0", mk(60'h0F0F0F0F0F0F0F0, 12'h000, 6'h10), 60'h0F0F0F0F0F0F0F0, 2'd1);
    cycle(1'b0, '0, 1'b1, acc);
    chk("directed_count", 64'(frame_count), 64'd5);

    // Reset with two frames in flight
    cycle(1'b1, rand_frame(), 1'b0, acc);
    cycle(1'b1, rand_frame(), 1'b0, acc);
    chk("mid_two_in_flight", 64'(out_valid), 64'h1);
    Rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_frame_count", 64'(frame_count), 64'h0);
    chk("mid_rst_out_data", 64'(out_data), 64'h0);
    clear_model();
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'h1);
    @(negedge Clk);
    for (int n = 0; n < 3; n++) begin
      cycle(1'b0, '0, 1'b1, acc);
      chk("mid_no_stale", 64'(out_valid), 64'h0);
    end

    // Backpressure: two accepted, third stalls until out_ready rises
    cycle(1'b1, mk(60'h111, 12'h0AA, 6'h01), 1'b0, acc);
    chk("bp_acc1", 64'(acc), 64'h1);
    cycle(1'b1, mk(60'h222, 12'h0BB, 6'h15), 1'b0, acc);
    chk("bp_acc2", 64'(acc), 64'h1);
    cur = mk(60'h333, 12'h0CC, 6'h2F);
    cycle(1'b1, cur, 1'b0, acc);
    chk("bp_stall3", 64'(acc), 64'h0);
    cycle(1'b1, cur, 1'b1, acc);
    chk("bp_acc3", 64'(acc), 64'h1);
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    chk("bp_count", 64'(frame_count), 64'd3);
    chk("bp_drained", 64'(out_valid), 64'h0);

    // Random traffic; a refused frame is held stable until accepted
    have = 1'b0;
    cur  = '0;
    for (int n = 0; n < 400; n++) begin
      if (!have) begin
        have = ($urandom_range(0, 9) < 7);
        cur  = rand_frame();
      end
      cycle(have, cur, ($urandom_range(0, 9) < 6), acc);
      if (acc) have = 1'b0;
    end
    for (int n = 0; n < 10 && q_data.size() > 0; n++) cycle(1'b0, '0, 1'b1, acc);
    chk("rand_drain_left", 64'(q_data.size()), 64'h0);
    chk("rand_drain_valid", 64'(out_valid), 64'h0);

    // Per-mode statistics: two mode-0 and one mode-3 delivery after a fresh reset
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    clear_model();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    cycle(1'b1, mk(60'hABCDE, 12'h123, 6'h01), 1'b1, acc);
    cycle(1'b1, mk(60'h12345, 12'h456, 6'h0F), 1'b1, acc);
    cycle(1'b1, mk(60'h77777, 12'h789, 6'h3A), 1'b1, acc);
    for (int n = 0; n < 3; n++) cycle(1'b0, '0, 1'b1, acc);
    stats_sel = 2'd0;
    #1;
    chk("stats_mode0", 64'(stats_count), STATS_ON ? 64'd2 : 64'd0);
    stats_sel = 2'd3;
    #1;
    chk("stats_mode3", 64'(stats_count), STATS_ON ? 64'd1 : 64'd0);
    stats_sel = 2'd1;
    #1;
    chk("stats_mode1", 64'(stats_count), 64'h0);
    chk("stats_count_total", 64'(frame_count), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decrypt_dispatch_pipe.md
Name: decrypt_dispatch_pipe

Overview:
Parametrised, pipelined successor to the four-way selector-driven decrypter. It accepts one framed ciphertext word per handshake and decodes a mode field from the frame's selector bits. It applies one of four built-in decrypt transforms and returns the plaintext through a valid/ready output with full backpressure. It sits between the link receiver and the plaintext consumer.

Parameters:
PAY_W, 60, payload/plaintext width in bits; must be >= 2^(SEL_W-2)
KEY_W, 12, key-seed width in bits; 1 <= KEY_W <= PAY_W
SEL_W, 6, selector width in bits; must be >= 3. Mode = sel[SEL_W-1:SEL_W-2]; rotate amount r = sel[SEL_W-3:0]
CNT_W, 16, width of frame_count and stats counters

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input frame valid
in_ready  out  1  block can accept a frame this cycle
in_frame  in  PAY_W+KEY_W+SEL_W  frame = {payload, key, sel}; sel occupies the LSBs
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts plaintext
out_data  out  PAY_W  decrypted plaintext
out_mode  out  2  mode used for out_data
frame_count  out  CNT_W  count of frames delivered (out_valid && out_ready); wraps modulo 2^CNT_W
stats_sel  in  2  mode whose counter is shown on stats_count
stats_count  out  CNT_W  per-mode delivered count (see Optional Feature)

Behaviour:
- Reset: the single clock is Clk; reset Rst_n is asynchronous and active-low. While Rst_n=0, all pipeline valid bits, out_valid, out_data, out_mode, frame_count and stats counters are 0. in_ready is 1 from the first cycle after release.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready. in_frame must be stable while in_valid=1 and in_ready=0.
- Stage S1 registers payload P, mode and r. It also registers the expanded key K = {key replicated ceil(PAY_W/KEY_W) times}[PAY_W-1:0].
- Stage S2 computes the transform and registers out_data and out_mode. S2 is the output register.
- Latency: 2 cycles from input transfer to out_valid when there is no stall. Throughput is 1 frame per cycle.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 loads when in_valid and (!s1_valid || S2 loads).
  - in_ready = !s1_valid || !out_valid || out_ready.
- Capacity and ordering: at most 2 frames are in flight. Order is strictly preserved, with no drop or duplication under any stall pattern.
- Modes (all arithmetic is modulo 2^PAY_W):
  - 0: P ^ K
  - 1: rotate_right(P, r) ^ K
  - 2: P - K
  - 3: bitreverse(P) ^ K, where bit i moves to bit PAY_W-1-i
- Mode decode matches the legacy thresholds for SEL_W=6: sel<16 is mode 0, <32 mode 1, <48 mode 2, <64 mode 3.
- Rotate boundary: r=0 leaves P unchanged.
- frame_count increments on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous events: an input and an output transfer in the same cycle is legal. The pipeline shifts, and both counts update.
- Reset mid-operation: in-flight frames are discarded and no partial output is produced.

Optional Feature:
DECRYPT_STATS_EN
- Defined: four CNT_W-bit per-mode counters. The counter for out_mode increments on each output transfer and saturates at all-ones. stats_count = counter[stats_sel], combinational. Counters reset to 0.
- Undefined: no counters are built. stats_count is tied to 0 and stats_sel is ignored.

Test Plan:
Mode 0: sel=0x05, key=0xABC, payload=0x123456789ABCDEF, out_ready=1 -> 2 cycles later out_valid=1, out_data=0xB9FEEAD35000753, out_mode=0.
Mode 2: sel=0x20, key=0x001, payload=0 -> out_data=0xFFEFFEFFEFFEFFF (wrap), out_mode=2.
Modes 1 and 3: sel=0x11 (r=1), key=0, payload=1 -> out_data=0x800000000000000. Then sel=0x30, key=0, payload=0x3 -> out_data=0xC00000000000000.
Backpressure: hold out_ready=0 and offer 3 frames back-to-back -> first 2 accepted, in_ready=0 on the 3rd. Raise out_ready -> all 3 delivered in order, one per cycle, frame_count=3.
Reset mid-stream: assert Rst_n=0 with 2 frames in flight -> out_valid=0 and frame_count=0 immediately (asynchronous). After release, in_ready=1 and no stale output appears.
Stats (macro defined): deliver 2 mode-0 frames and 1 mode-3 frame -> stats_sel=0 gives 2 and stats_sel=3 gives 1. With the macro undefined, stats_count=0.
